tug_game_ctrl: RTL and testbench
================================

// Module: tug_game_ctrl
// PURPOSE
//   Round/match controller for the tug-of-war light row. Turns raw player key levels into
//   one-cycle move pulses for every light cell, detects a point when the end light is lit and
//   its owner presses, keeps per-player scores, and drives the row-wide round restart (res).
//   Declares the match winner and freezes play at WIN_SCORE.
// PARAMETERS
//   NUM_LIGHTS    9   cells in the row; leds[NUM_LIGHTS-1] = leftmost, leds[0] = rightmost
//   SCORE_W       3   score counter width
//   WIN_SCORE     7   points that end the match (must be < 2**SCORE_W)
//   PAUSE_CYCLES  4   cycles res is held after a point (>=1)
// PORTS
//   clk        in   1           system clock
//   reset      in   1           synchronous, active-high reset
//   key_l      in   1           left player key level, already synchronised, 1 = pressed
//   key_r      in   1           right player key level, already synchronised, 1 = pressed
//   leds       in   NUM_LIGHTS  lightOn of each cell, bit NUM_LIGHTS-1 = leftmost
//   L          out  1           left move pulse to all cells (registered)
//   R          out  1           right move pulse to all cells (registered)
//   res        out  1           round restart to all cells (center on, others off)
//   score_l    out  SCORE_W     left player score
//   score_r    out  SCORE_W     right player score
//   winner     out  2           00 none, 01 left, 10 right
//   game_over  out  1           match finished
// BEHAVIOUR
//   - Reset: state PLAY; L=R=res=0; scores 0; winner 00; game_over 0; key history regs cleared
//     to 1 so a key held through reset produces no edge.
//   - Edge detect: l_edge = key_l & ~key_l_q (same for r). Holding a key gives one pulse only.
//   - States: PLAY, PAUSE, OVER. All outputs registered; 1-cycle latency edge -> output.
//   - PLAY, no point: L <= l_edge, R <= r_edge. Both edges same cycle -> L=R=1 (cells hold).
//   - Point left: leds[NUM_LIGHTS-1] & l_edge & ~r_edge. Point right: leds[0] & r_edge & ~l_edge.
//     Winning press is NOT forwarded (L=R=0). score_x increments next cycle.
//       - new score == WIN_SCORE -> OVER; winner set; game_over=1; res=0; L/R stay 0.
//       - else -> PAUSE; res=1 from next cycle for exactly PAUSE_CYCLES cycles (down-counter).
//   - Simultaneous point conditions are impossible by the ~other_edge term; both edges with an
//     end light on -> no point, L=R=1.
//   - PAUSE: L=R=0; key edges discarded (history regs still update). On counter reaching 0:
//     res=0, -> PLAY. First move pulse possible on the cycle after res drops.
//   - OVER: absorbing; L=R=res=0; scores/winner frozen until reset.
//   - Reset at any time (incl. mid-PAUSE or OVER) restores reset values next cycle; scores cleared.
//   - Scores never exceed WIN_SCORE; no wrap logic required.
// STRUCTURE
//   - tug_pkg: typedef enum logic [1:0] {PLAY, PAUSE, OVER} game_state_t;
//     winner encodings WIN_NONE/WIN_LEFT/WIN_RIGHT.
//   - Sub-module key_edge (clk, reset, key, edge), instantiated for key_l and key_r.
//   - Top holds the FSM, pause counter ($clog2(PAUSE_CYCLES+1) bits), score counters.
// TESTING (clock_period 100, defaults)
//   1 Reset with key_l held 1 -> no L pulse; release, press once -> L=1 one cycle, held key no repeat.
//   2 key_l & key_r rise same cycle, leds=9'b000010000 -> L=1 and R=1 same cycle, no score change.
//   3 leds=9'b100000000, key_l rises -> L=0, score_l 0->1, res=1 for 4 cycles, then PLAY.
//   4 During PAUSE press key_r -> R stays 0; press after res drops -> R=1.
//   5 Drive 7 right points -> score_r=7, winner=10, game_over=1, later presses give no pulses.
//   6 Assert reset in PAUSE cycle 2 -> res=0, scores 0, state PLAY next cycle.

Source files
------------

// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared types and encodings for the tug-of-war match controller
//   game_state_t : PLAY (normal moves), PAUSE (round restart), OVER (match finished)
//   WIN_*        : encodings driven on tug_game_ctrl.winner
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        PAUSE = 2'd1,
        OVER  = 2'd2
    } game_state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - rising-edge detector for one synchronised player key
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   key   in  key level, 1 = pressed
//   pulse out 1 for the cycle in which key rises (combinational from key and history)
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pulse
);

    logic key_q;

    // History resets to 1 so a key held through reset does not register as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= 1'b1;
        end else begin
            key_q <= key;
        end
    end

    assign pulse = key & ~key_q;

endmodule

// File: rtl/tug_game_ctrl.sv
// rtl/tug_game_ctrl.sv - round/match controller for the tug-of-war light row
//   clk, reset       system clock, synchronous active-high reset
//   key_l, key_r     synchronised player key levels, 1 = pressed
//   leds             lightOn of each cell, bit NUM_LIGHTS-1 = leftmost
//   L, R             registered one-cycle move pulses to all cells
//   res              round restart to all cells, held PAUSE_CYCLES cycles after a point
//   score_l, score_r per-player scores
//   winner           WIN_NONE / WIN_LEFT / WIN_RIGHT
//   game_over        match finished, play frozen until reset
module tug_game_ctrl
    import tug_pkg::*;
#(
    parameter int NUM_LIGHTS   = 9,
    parameter int SCORE_W      = 3,
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_l,
    input  logic                  key_r,
    input  logic [NUM_LIGHTS-1:0] leds,
    output logic                  L,
    output logic                  R,
    output logic                  res,
    output logic [SCORE_W-1:0]    score_l,
    output logic [SCORE_W-1:0]    score_r,
    output logic [1:0]            winner,
    output logic                  game_over
);

    localparam int CNT_W = $clog2(PAUSE_CYCLES + 1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   PAUSE_TOP = CNT_W'(PAUSE_CYCLES - 1);

    game_state_t      state;
    logic [CNT_W-1:0] pause_cnt;
    logic             l_edge;
    logic             r_edge;
    logic             point_l;
    logic             point_r;
    logic             unused_leds;

    key_edge u_edge_l (
        .clk   (clk),
        .reset (reset),
        .key   (key_l),
        .pulse (l_edge)
    );

    key_edge u_edge_r (
        .clk   (clk),
        .reset (reset),
        .key   (key_r),
        .pulse (r_edge)
    );

    // A press scores only when its own end light is lit and the opponent is not
    // pressing in the same cycle; a tie is treated as an ordinary (cancelling) move.
    assign point_l = leds[NUM_LIGHTS-1] & l_edge & ~r_edge;
    assign point_r = leds[0] & r_edge & ~l_edge;

    // Interior cells never influence scoring.
    assign unused_leds = ^leds[NUM_LIGHTS-2:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLAY;
            pause_cnt <= '0;
            L         <= 1'b0;
            R         <= 1'b0;
            res       <= 1'b0;
            score_l   <= '0;
            score_r   <= '0;
            winner    <= WIN_NONE;
            game_over <= 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    if (point_l || point_r) begin
                        // The scoring press is swallowed so the row does not step off the end.
                        L <= 1'b0;
                        R <= 1'b0;
                        if (point_l) begin
                            score_l <= score_l + 1'b1;
                        end else begin
                            score_r <= score_r + 1'b1;
                        end
                        if ((point_l && (score_l + 1'b1) == WIN_VAL) ||
                            (point_r && (score_r + 1'b1) == WIN_VAL)) begin
                            state     <= OVER;
                            winner    <= point_l ? WIN_LEFT : WIN_RIGHT;
                            game_over <= 1'b1;
                            res       <= 1'b0;
                        end else begin
                            state     <= PAUSE;
                            res       <= 1'b1;
                            pause_cnt <= PAUSE_TOP;
                        end
                    end else begin
                        L <= l_edge;
                        R <= r_edge;
                    end
                end
                PAUSE: begin
                    // Presses during the restart are dropped; res stays high until the count expires.
                    L <= 1'b0;
                    R <= 1'b0;
                    if (pause_cnt == '0) begin
                        res   <= 1'b0;
                        state <= PLAY;
                    end else begin
                        pause_cnt <= pause_cnt - 1'b1;
                    end
                end
                OVER: begin
                    L   <= 1'b0;
                    R   <= 1'b0;
                    res <= 1'b0;
                end
                default: begin
                    state <= PLAY;
                    L     <= 1'b0;
                    R     <= 1'b0;
                    res   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tug_game_ctrl.sv
// tb/tb_tug_game_ctrl.sv - directed self-checking bench for tug_game_ctrl
module tb_tug_game_ctrl;

    logic       clk;
    logic       reset;
    logic       key_l;
    logic       key_r;
    logic [8:0] leds;
    logic       L;
    logic       R;
    logic       res;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic [1:0] winner;
    logic       game_over;

    int checks;
    int errors;

    tug_game_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .key_l     (key_l),
        .key_r     (key_r),
        .leds      (leds),
        .L         (L),
        .R         (R),
        .res       (res),
        .score_l   (score_l),
        .score_r   (score_r),
        .winner    (winner),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Advance one clock and settle before sampling.
    task automatic step();
        @(posedge clk);
        #10;
    endtask

    task automatic test_reset();
        reset = 1'b1; key_l = 1'b1; key_r = 1'b0; leds = 9'b000010000;
        step(); step();
        checks++;
        if ({L, R, res, score_l, score_r, winner, game_over} !== 12'b0) begin
            errors++;
            $display("FAIL reset_state: got L%b R%b res%b sl%0d sr%0d w%b go%b, want all zero",
                     L, R, res, score_l, score_r, winner, game_over);
        end
        reset = 1'b0;
        step(); step();
        checks++;
        if (L !== 1'b0) begin
            errors++;
            $display("FAIL held_through_reset: L=%b want 0", L);
        end
        key_l = 1'b0; step();
        key_l = 1'b1; step();
        checks++;
        if (L !== 1'b1 || R !== 1'b0) begin
            errors++;
            $display("FAIL single_press: L=%b R=%b want L=1 R=0", L, R);
        end
        step();
        checks++;
        if (L !== 1'b0) begin
            errors++;
            $display("FAIL held_no_repeat: L=%b want 0", L);
        end
        key_l = 1'b0; step();
    endtask

    task automatic test_both_keys();
        leds = 9'b000010000;
        key_l = 1'b1; key_r = 1'b1; step();
        checks++;
        if (L !== 1'b1 || R !== 1'b1 || score_l !== 3'd0 || score_r !== 3'd0) begin
            errors++;
            $display("FAIL both_keys: L=%b R=%b sl=%0d sr=%0d want 1 1 0 0", L, R, score_l, score_r);
        end
        step();
        checks++;
        if (L !== 1'b0 || R !== 1'b0) begin
            errors++;
            $display("FAIL both_keys_release: L=%b R=%b want 0 0", L, R);
        end
        key_l = 1'b0; key_r = 1'b0; step();
    endtask

    task automatic test_point_left();
        leds = 9'b100000000;
        key_l = 1'b1; step();
        checks++;
        if (L !== 1'b0 || score_l !== 3'd1 || res !== 1'b1) begin
            errors++;
            $display("FAIL point_left: L=%b sl=%0d res=%b want 0 1 1", L, score_l, res);
        end
        key_l = 1'b0; leds = 9'b000010000;
        for (int i = 2; i <= 4; i++) begin
            step();
            checks++;
            if (res !== 1'b1) begin
                errors++;
                $display("FAIL res_hold_%0d: res=%b want 1", i, res);
            end
        end
        step();
        checks++;
        if (res !== 1'b0) begin
            errors++;
            $display("FAIL res_drop: res=%b want 0", res);
        end
    endtask

    task automatic test_pause_discard();
        leds = 9'b100000000;
        key_l = 1'b1; step();
        checks++;
        if (score_l !== 3'd2 || res !== 1'b1) begin
            errors++;
            $display("FAIL second_point: sl=%0d res=%b want 2 1", score_l, res);
        end
        key_l = 1'b0; leds = 9'b000010000;
        key_r = 1'b1; step();
        checks++;
        if (R !== 1'b0 || res !== 1'b1) begin
            errors++;
            $display("FAIL pause_discard: R=%b res=%b want 0 1", R, res);
        end
        key_r = 1'b0; step(); step(); step();
        checks++;
        if (res !== 1'b0) begin
            errors++;
            $display("FAIL pause_end: res=%b want 0", res);
        end
        key_r = 1'b1; step();
        checks++;
        if (R !== 1'b1) begin
            errors++;
            $display("FAIL first_after_pause: R=%b want 1", R);
        end
        key_r = 1'b0; step();
    endtask

    task automatic test_match_win();
        leds = 9'b000000001;
        for (int i = 1; i <= 7; i++) begin
            key_r = 1'b1; step();
            checks++;
            if (score_r !== 3'(i) || R !== 1'b0) begin
                errors++;
                $display("FAIL right_point_%0d: sr=%0d R=%b want %0d 0", i, score_r, R, i);
            end
            key_r = 1'b0;
            if (i < 7) begin
                step(); step(); step(); step();
            end
        end
        checks++;
        if (winner !== 2'b10 || game_over !== 1'b1 || res !== 1'b0) begin
            errors++;
            $display("FAIL match_over: w=%b go=%b res=%b want 10 1 0", winner, game_over, res);
        end
        step();
        key_r = 1'b1; key_l = 1'b1; step();
        checks++;
        if (L !== 1'b0 || R !== 1'b0 || score_r !== 3'd7 || score_l !== 3'd2 || winner !== 2'b10) begin
            errors++;
            $display("FAIL frozen: L=%b R=%b sr=%0d sl=%0d w=%b want 0 0 7 2 10",
                     L, R, score_r, score_l, winner);
        end
        key_r = 1'b0; key_l = 1'b0; step();
    endtask

    task automatic test_reset_in_pause();
        reset = 1'b1; step();
        reset = 1'b0; step();
        leds = 9'b100000000;
        key_l = 1'b1; step();
        checks++;
        if (res !== 1'b1 || score_l !== 3'd1 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL pause_entry: res=%b sl=%0d go=%b want 1 1 0", res, score_l, game_over);
        end
        key_l = 1'b0; leds = 9'b000010000; step();
        reset = 1'b1; step();
        checks++;
        if (res !== 1'b0 || score_l !== 3'd0 || score_r !== 3'd0 || winner !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_pause: res=%b sl=%0d sr=%0d w=%b want 0 0 0 00",
                     res, score_l, score_r, winner);
        end
        reset = 1'b0; step();
        key_l = 1'b1; step();
        checks++;
        if (L !== 1'b1) begin
            errors++;
            $display("FAIL play_after_reset: L=%b want 1", L);
        end
        key_l = 1'b0; step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_both_keys();
        test_point_left();
        test_pause_discard();
        test_match_win();
        test_reset_in_pause();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
